// File: rtl/lf_read_sequencer_pkg.sv
// Shared constants, state encoding and divisor clamp for the LF read sequencer.
package lf_read_sequencer_pkg;

  localparam int CNT_W   = 8;   // divider phase counter / divisor width
  localparam int BURST_W = 16;  // charge / sample period counter width

  localparam logic [CNT_W-1:0] DIV_MIN   = CNT_W'(15);  // smallest legal half-period
  localparam logic [CNT_W-1:0] DIV_RST   = CNT_W'(95);  // 125 kHz carrier at 24 MHz
  localparam logic [CNT_W-1:0] ADC_PHASE = CNT_W'(7);   // ADC-valid point in the low half

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARM    = 2'd1,
    ST_CHARGE = 2'd2,
    ST_SAMPLE = 2'd3
  } state_e;

  // Programmed divisors below DIV_MIN would starve the ADC capture phase.
  function automatic logic [CNT_W-1:0] clamp_div(input logic [CNT_W-1:0] d);
    return (d < DIV_MIN) ? DIV_MIN : d;
  endfunction

endpackage

// File: rtl/lf_read_sequencer_if.sv
// Control/status bundle between the ARM-side controller and the LF read sequencer.
interface lf_read_sequencer_if;
  import lf_read_sequencer_pkg::*;

  logic [CNT_W-1:0]   divisor;
  logic [BURST_W-1:0] charge_periods;
  logic [BURST_W-1:0] sample_periods;
  logic               start;
  logic               abort;

  logic [CNT_W-1:0]   pck_cnt;
  logic               pck_divclk;
  logic               lf_field;
  logic               sample_stb;
  logic               frame_en;
  logic               busy;
  logic               done;

  // Controller side: issues configuration and commands, observes timing/status.
  modport master (
    output divisor, charge_periods, sample_periods, start, abort,
    input  pck_cnt, pck_divclk, lf_field, sample_stb, frame_en, busy, done
  );

  // Sequencer side.
  modport slave (
    input  divisor, charge_periods, sample_periods, start, abort,
    output pck_cnt, pck_divclk, lf_field, sample_stb, frame_en, busy, done
  );

endinterface

// File: rtl/lf_read_sequencer_clk_divider.sv
// Free-running carrier divider: phase counter, carrier clock and period tick.
module lf_clk_divider
  import lf_read_sequencer_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] divisor,
  output logic [CNT_W-1:0] pck_cnt,
  output logic             pck_divclk,
  output logic             period_tick
);

  logic [CNT_W-1:0] div_reg;
  logic             wrap;

  assign wrap        = (pck_cnt == div_reg);
  // The wrap that is about to raise pck_divclk marks the start of a carrier period.
  assign period_tick = wrap & ~pck_divclk;

  // Phase counter; the divisor is only reloaded on a wrap so no half-period is cut short.
  always_ff @(posedge clk) begin
    // NOTE: reset is sampled on the clock edge (synchronous), and all state uses <=
    // so every register sees the pre-edge values of its neighbours.
    if (!rst_n) begin
      pck_cnt    <= '0;
      pck_divclk <= 1'b0;
      div_reg    <= DIV_RST;
    end else if (wrap) begin
      pck_cnt    <= '0;
      pck_divclk <= ~pck_divclk;
      div_reg    <= clamp_div(divisor);
    end else begin
      pck_cnt    <= pck_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/lf_read_sequencer.sv
// LF read sequencer: charge-then-sample burst FSM on top of the carrier divider.
module lf_read_sequencer
  import lf_read_sequencer_pkg::*;
(
  input  logic pck0,
  input  logic rst_n,
  lf_read_sequencer_if.slave bus
);

  state_e             state, state_nx;
  logic [BURST_W-1:0] charge_cnt, charge_cnt_nx;
  logic [BURST_W-1:0] sample_cnt, sample_cnt_nx;
  logic               done_c;
  logic [CNT_W-1:0]   pck_cnt;
  logic               pck_divclk;
  logic               period_tick;

  lf_clk_divider u_div (
    .clk         (pck0),
    .rst_n       (rst_n),
    .divisor     (bus.divisor),
    .pck_cnt     (pck_cnt),
    .pck_divclk  (pck_divclk),
    .period_tick (period_tick)
  );

  // State and burst counter registers.
  always_ff @(posedge pck0) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      charge_cnt <= '0;
      sample_cnt <= '0;
    end else begin
      state      <= state_nx;
      charge_cnt <= charge_cnt_nx;
      sample_cnt <= sample_cnt_nx;
    end
  end

  // Next-state logic; abort takes priority over start and over period ticks.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_nx      = state;
    charge_cnt_nx = charge_cnt;
    sample_cnt_nx = sample_cnt;
    done_c        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.start && !bus.abort) begin
          state_nx      = ST_ARM;
          charge_cnt_nx = bus.charge_periods;
          sample_cnt_nx = bus.sample_periods;
        end
      end
      ST_ARM: begin
        if (bus.abort) begin
          state_nx = ST_IDLE;
        end else if (period_tick) begin
          state_nx = (charge_cnt != '0) ? ST_CHARGE : ST_SAMPLE;
        end
      end
      ST_CHARGE: begin
        if (bus.abort) begin
          state_nx = ST_IDLE;
        end else if (period_tick && charge_cnt != '0) begin
          charge_cnt_nx = charge_cnt - BURST_W'(1);
          if (charge_cnt == BURST_W'(1)) state_nx = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        // A zero sample count never decrements, giving continuous sampling.
        if (bus.abort) begin
          state_nx = ST_IDLE;
        end else if (period_tick && sample_cnt != '0) begin
          sample_cnt_nx = sample_cnt - BURST_W'(1);
          if (sample_cnt == BURST_W'(1)) begin
            state_nx = ST_IDLE;
            done_c   = 1'b1;
          end
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  assign bus.pck_cnt    = pck_cnt;
  assign bus.pck_divclk = pck_divclk;
  assign bus.lf_field   = (state == ST_CHARGE) || (state == ST_SAMPLE);
  assign bus.frame_en   = (state == ST_SAMPLE);
  assign bus.busy       = (state != ST_IDLE);
  assign bus.sample_stb = (state == ST_SAMPLE) && (pck_cnt == ADC_PHASE) && !pck_divclk;
  assign bus.done       = done_c;

endmodule

// File: doc/lf_read_sequencer.md
Name: lf_read_sequencer

Overview:
- Timing and sequencing controller for the LF read datapath.
- Generates the carrier divider pair (pck_cnt, pck_divclk) from pck0.
- Runs a charge-then-sample acquisition burst: field on for N carrier periods, then M sampled periods.
- Emits the ADC-capture strobe and SSP frame enable for the serializer, plus start/busy/done status for the ARM-side control logic.

Parameters:
- CNT_W, 8, width of pck_cnt and divisor.
- BURST_W, 16, width of the charge/sample period counters.
- DIV_MIN, 15, minimum legal divisor; smaller programmed values are clamped up to this.
- DIV_RST, 95, divisor after reset (125 kHz carrier at 24 MHz pck0).

Ports:
- pck0  in  1  system clock, 24 MHz.
- rst_n  in  1  synchronous active-low reset.
- divisor  in  CNT_W  half-period length minus 1, in pck0 cycles.
- charge_periods  in  BURST_W  carrier periods with field on before sampling.
- sample_periods  in  BURST_W  carrier periods sampled; 0 = continuous until abort.
- start  in  1  one-cycle request to begin a burst.
- abort  in  1  one-cycle request to terminate the burst.
- pck_cnt  out  CNT_W  divider phase counter.
- pck_divclk  out  1  carrier-rate clock; toggles when pck_cnt wraps.
- lf_field  out  1  field enable for the antenna driver.
- sample_stb  out  1  one-cycle ADC capture strobe.
- frame_en  out  1  SSP frame gate; high during SAMPLE.
- busy  out  1  high in ARM, CHARGE and SAMPLE.
- done  out  1  one-cycle pulse on normal completion.

Behaviour:
- Clocking: single clock pck0. rst_n is synchronous, active-low, and overrides everything.
- Reset values: pck_cnt=0, pck_divclk=0, div_reg=DIV_RST, state=IDLE, all other outputs 0.
- Divider: pck_cnt increments every pck0 cycle. When pck_cnt==div_reg it wraps to 0 and pck_divclk toggles. Carrier period = 2*(div_reg+1) pck0 cycles.
- div_reg loads max(divisor, DIV_MIN) only in the cycle pck_cnt wraps, so a live divisor change never truncates a half-period.
- Period tick (internal): the cycle in which pck_divclk goes 0->1.
- The divider free-runs in every state, including IDLE.
- sample_stb: asserted only in SAMPLE, for the one cycle with pck_cnt==7 and pck_divclk==0 (the ADC-valid point, low half of the carrier).
- frame_en = (state==SAMPLE); the SSP serializer ANDs this with its own frame timing.
- FSM states: IDLE, ARM, CHARGE, SAMPLE.
  - IDLE: lf_field=0, busy=0. start -> ARM. Burst counters load charge_periods and sample_periods.
  - ARM: lf_field=0, busy=1. Waits for the next period tick, so the field always starts aligned to a carrier period. At the tick: go to CHARGE if charge_periods!=0, else SAMPLE.
  - CHARGE: lf_field=1. Charge counter decrements on each period tick. On the tick where it reaches 0 -> SAMPLE.
  - SAMPLE: lf_field=1. If sample_periods!=0, the counter decrements on each period tick; on the tick where it reaches 0 -> IDLE, with done=1 in that same transition cycle. If sample_periods==0, stay in SAMPLE until abort.
- Input latching: charge_periods, sample_periods and divisor are sampled as described above. Later changes do not affect a running burst, except divisor, which takes effect at the next wrap.
- start while busy: ignored, no queuing.
- abort: from any non-IDLE state -> IDLE next cycle. lf_field, frame_en and busy drop that cycle; done is not pulsed. abort in IDLE has no effect.
- start and abort in the same cycle: abort wins; the state stays or becomes IDLE.
- Period tick coinciding with abort: abort wins.
- Reset mid-burst: immediate return to IDLE; the divider restarts from 0 with div_reg=DIV_RST.
- Counter arithmetic: unsigned; no wrap below 0 because zero is checked before decrement.

Decomposition:
- Shared package holds the state encoding typedef (2-bit: IDLE=0, ARM=1, CHARGE=2, SAMPLE=3), DIV_MIN, DIV_RST and the ADC capture phase constant (7).
- One sub-module, lf_clk_divider: pck_cnt, pck_divclk, the div_reg load and clamp, and the period-tick output. The FSM and burst counters stay in the top level.

Test Plan:
- Reset, divisor=95, no start -> pck_divclk period 192 cycles, pck_cnt wraps at 95, lf_field=0, busy=0.
- divisor=3 -> clamped to 15; pck_divclk period 32 cycles.
- charge=2, sample=3, start -> busy high next cycle; lf_field rises at the first period tick; 2 periods later frame_en=1; exactly 3 sample_stb pulses, each at pck_cnt==7, pck_divclk==0; done pulses once; lf_field drops with done.
- charge=0, sample=0, start -> SAMPLE directly at the first period tick, continuous sample_stb once per period; abort -> IDLE next cycle, no done.
- start and abort asserted together in IDLE -> stays IDLE. start during CHARGE -> ignored, burst length unchanged.
- divisor changed 95->47 mid-SAMPLE -> current half-period completes at 96 cycles; later half-periods are 48 cycles; rst_n low mid-burst -> all outputs 0 next cycle.
